// File: rtl/shift_add_mac.sv
// Serial shift-and-add multiply-accumulate: walks the set bits of a Q1.15 coefficient
// through one shared barrel shifter into a wide signed accumulator; latency popcount(coef)+1.
module shift_add_mac #(
    parameter int ACC_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        acc_clr,
    input  logic [15:0] x,
    input  logic [15:0] coef,
    output logic        ready,
    output logic        done,
    output logic [15:0] y,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic signed [ACC_W-1:0] MAX16 = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN16 = ACC_W'(-32768);

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [15:0]       mask;
    logic        [15:0]       xr;

    logic        [3:0]        bit_idx;
    logic signed [4:0]        shamt;
    logic        [15:0]       shifted;
    logic signed [ACC_W-1:0]  term;
    logic        [15:0]       mask_nxt;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     enter_done;
    logic        [15:0]       y_nxt;
    logic                     ovf_nxt;

    // Shared shifter: signed amount, positive = right, negative = left; low 16 bits kept.
    function automatic logic [15:0] barrel16(input logic [15:0] d,
                                             input logic signed [4:0] s,
                                             input logic arith);
        logic [31:0] ext;
        logic [31:0] sh;
        logic [4:0]  neg;
        ext = {{16{arith & d[15]}}, d};
        sh  = 32'd0;
        neg = 5'd0;
        if (s >= 0) begin
            sh = ext >> s[3:0];
        end else begin
            neg = 5'(-s);
            sh  = {16'd0, d} << neg;
        end
        return sh[15:0];
    endfunction

    always_comb begin
        bit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) bit_idx = 4'(i);
        end
    end

    // Bit 15 maps to shift 0 and is subtracted (sign weight of Q1.15).
    assign shamt    = signed'({1'b0, 4'(4'd15 - bit_idx)});
    assign shifted  = barrel16(xr, shamt, 1'b1);
    assign term     = ACC_W'(signed'(shifted));
    assign mask_nxt = mask & ~(16'd1 << bit_idx);

    always_comb begin
        acc_nxt    = acc;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (acc_clr) acc_nxt = '0;
                    enter_done = (coef == 16'd0);
                end
            end
            RUN: begin
                acc_nxt    = (bit_idx == 4'd15) ? acc - term : acc + term;
                enter_done = (mask_nxt == 16'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        y_nxt   = acc_nxt[15:0];
        ovf_nxt = 1'b0;
        if (acc_nxt > MAX16) begin
            y_nxt   = 16'h7FFF;
            ovf_nxt = 1'b1;
        end else if (acc_nxt < MIN16) begin
            y_nxt   = 16'h8000;
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            mask  <= '0;
            xr    <= '0;
            y     <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x;
                        mask  <= coef;
                        acc   <= acc_nxt;
                        state <= (coef != 16'd0) ? RUN : FIN;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    mask <= mask_nxt;
                    if (mask_nxt == 16'd0) state <= FIN;
                end
                default: state <= IDLE;
            endcase
            // y/ovf update on the edge that enters FIN so they are stable while done is high.
            if (enter_done) begin
                y    <= y_nxt;
                ovf  <= ovf_nxt;
                done <= 1'b1;
            end
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_shift_add_mac.sv
// Directed-vector bench for shift_add_mac: table of multiplies plus reset and back-to-back sequences.
module tb_shift_add_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc_clr;
    logic [15:0] x;
    logic [15:0] coef;
    logic        ready;
    logic        done;
    logic [15:0] y;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    shift_add_mac #(.ACC_W(20)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .acc_clr (acc_clr),
        .x       (x),
        .coef    (coef),
        .ready   (ready),
        .done    (done),
        .y       (y),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] coef;
        logic        clr;
        logic        noise;
        logic [15:0] exp_y;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts in the first ready cycle, checks latency, y, ovf and the single-cycle done pulse.
    task automatic run_op(input string name, input vec_t v);
        int  wait_cnt;
        int  lat;
        bit  seen;
        wait_cnt = 0;
        while (!ready && wait_cnt < 40) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check({name, " ready before start"}, 32'(ready), 32'd1);
        x       = v.x;
        coef    = v.coef;
        acc_clr = v.clr;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy after accept"}, 32'(ready), 32'd0);
        lat  = 1;
        seen = done;
        while (!seen && lat < 40) begin
            if (v.noise) begin
                start   = 1'b1;
                acc_clr = 1'b1;
                x       = 16'h7FFF;
                coef    = 16'hFFFF;
            end
            @(posedge clk); #1;
            lat++;
            seen = done;
        end
        start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({name, " y"}, 32'(y), 32'(v.exp_y));
        check({name, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
        @(posedge clk); #1;
        check({name, " done pulse width"}, 32'(done), 32'd0);
        check({name, " y holds"}, 32'(y), 32'(v.exp_y));
    endtask

    vec_t vt[13];
    vec_t v;

    initial begin
        vt[0]  = '{16'h4000, 16'h4000, 1'b1, 1'b0, 16'h2000, 1'b0, 2};
        vt[1]  = '{16'h4000, 16'h8000, 1'b1, 1'b0, 16'hC000, 1'b0, 2};
        vt[2]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 1'b1, 2};
        vt[3]  = '{16'h8000, 16'h4000, 1'b0, 1'b0, 16'h4000, 1'b0, 2};
        vt[4]  = '{16'h0001, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b0, 16};
        vt[5]  = '{16'h0002, 16'h7FFF, 1'b1, 1'b0, 16'h0001, 1'b0, 16};
        vt[6]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFF1, 1'b0, 17};
        vt[7]  = '{16'h2000, 16'h4000, 1'b1, 1'b1, 16'h1000, 1'b0, 2};
        vt[8]  = '{16'h2000, 16'h2000, 1'b0, 1'b1, 16'h1800, 1'b0, 2};
        vt[9]  = '{16'hE000, 16'h4000, 1'b0, 1'b1, 16'h0800, 1'b0, 2};
        vt[10] = '{16'h8000, 16'h4000, 1'b1, 1'b0, 16'hC000, 1'b0, 2};
        vt[11] = '{16'h8000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 2};
        vt[12] = '{16'h8000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b1, 2};

        rst = 1'b1; start = 1'b0; acc_clr = 1'b0; x = '0; coef = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset y", 32'(y), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vt[i]);
        end

        // Reset in the middle of a 16-bit walk: no done, outputs and accumulator cleared.
        x = 16'h4000; coef = 16'hFFFF; acc_clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrun done c%0d", k), 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun rst ready", 32'(ready), 32'd1);
        check("midrun rst done", 32'(done), 32'd0);
        check("midrun rst y", 32'(y), 32'd0);
        check("midrun rst ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("post rst no done c%0d", k), 32'(done), 32'd0);
        end
        v = '{16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1};
        run_op("acc cleared by rst", v);

        // Back-to-back: each run_op starts in the first ready cycle after the previous done.
        v = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1};
        run_op("zero coef", v);
        v = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h2000, 1'b0, 2};
        run_op("b2b after zero", v);
        v = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h4000, 1'b0, 2};
        run_op("b2b chain", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
